dmem_responder: RTL
===================

Name: dmem_responder

Overview:
Data-memory responder serving the pipeline's MEM-stage load/store port through a valid/ready request and response handshake. It holds word-organised storage with configurable access latency. Stores are byte/half/word masked; loads are extracted and sign/zero-extended per funct3. The pipeline's hazard logic holds MEM while a request is outstanding (req_ready low or rsp_valid not yet seen).

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; word index = addr[31:2]
LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  32  byte address
req_wdata  input  32  store data, LSB-aligned
rsp_valid  output  1  response present
rsp_ready  input  1  pipeline accepts response
rsp_rdata  output  32  load result, extended; 0 for stores and errors
rsp_err  output  1  misaligned, out-of-range, or illegal funct3

Behaviour:
- Reset (synchronous, active-high): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. Storage is not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. Acceptance = req_valid & req_ready. On acceptance, capture we/funct3/addr/wdata into internal registers.
  - LATENCY=1: go to RESP.
  - LATENCY>1: go to WAIT with counter=LATENCY-2.
- WAIT: req_ready=0. Counter decrements each cycle. At counter==0, go to RESP.
- Entering RESP (a single-cycle action):
  - Error check is performed.
  - If no error and store: write the masked lanes.
  - If no error and load: read the word and extract the data.
  - rsp_valid=1 from the first RESP cycle.
- RESP: req_ready=0. Outputs are held stable until rsp_ready=1. On rsp_valid & rsp_ready, go to IDLE and clear rsp_valid the next cycle.
- Back-to-back requests are not allowed: a new request is accepted only from IDLE. Throughput is one request per LATENCY+1 cycles when rsp_ready is tied high.
- Error conditions (rsp_err=1, rsp_rdata=0, no storage write):
  - H/HU with addr[0]=1
  - W with addr[1:0]!=0
  - funct3 in {011, 110, 111}
  - addr[31:2] >= DEPTH_WORDS
- Store lanes:
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
  - Stores return rsp_rdata=0, rsp_err=0.
- Load extraction:
  - LB/LBU select byte lane addr[1:0]; LH/LHU select half addr[1].
  - Signed codes sign-extend from bit 7/15; U codes zero-extend.
- A store followed by a load to the same word returns the new data. No forwarding is needed because accesses are serialised.
- Reset asserted in WAIT returns to IDLE and drops the request: no write is committed. Reset in RESP clears rsp_valid; a write already committed on RESP entry stays committed.
- req_valid while not in IDLE is ignored. The requester must hold its request until it sees req_ready.

Optional Feature:
Macro DMEM_PERF_CNT_EN.
- Defined: adds outputs perf_loads[31:0], perf_stores[31:0], perf_errs[31:0] and perf_stall_cycles[31:0].
  - perf_loads / perf_stores / perf_errs increment on each RESP handshake of the matching kind.
  - perf_stall_cycles counts cycles with rsp_valid=1 & rsp_ready=0.
  - All counters reset to 0, wrap at 2^32, and are not cleared otherwise.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package (riscv_pkg, alongside const.svh): funct3 width constants F3_LB/F3_LH/F3_LW/F3_LBU/F3_LHU, the FSM state enum dmem_state_t {IDLE, WAIT, RESP}, and the lane-mask type logic [3:0].
- One natural sub-module: dmem_lane_align. It is purely combinational, takes funct3, addr[1:0], wdata and rword, and produces the write byte-enable, shifted write data, extended load data and the misalign flag. It is reused later by a fetch-side responder.

Test Plan:
- LATENCY=2, rsp_ready=1, SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> load rsp_valid 2 cycles after acceptance, rsp_rdata=0xDEADBEEF, rsp_err=0.
- After the word holds 0xDEADBEEF: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- SB 0x11 data 0x55, then LW 0x10 -> 0xDEAD55EF. SH 0x12 data 0x1234, then LW -> 0x123455EF.
- LW 0x12 and SH 0x13 -> rsp_err=1, rsp_rdata=0, memory unchanged (a subsequent LW 0x10 returns the prior value). Address 0x1000 with DEPTH_WORDS=1024 -> rsp_err=1.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0, a second req_valid is ignored; with DMEM_PERF_CNT_EN, perf_stall_cycles=5.
- LATENCY=4, SW accepted, rst pulsed in the 2nd WAIT cycle -> rsp_valid never asserts, req_ready=1 after reset, and a subsequent LW returns the old word.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: funct3 width codes, FSM states, lane mask.
package dmem_responder_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  typedef logic [3:0] lane_mask_t;

  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage load/store port bundle between the pipeline (master) and the responder (slave).
interface dmem_responder_if;
  // Both channels: a transfer happens on a rising edge where valid and ready are both high;
  // the source holds valid and its payload stable until that edge.
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte-enables/data, load extraction and extension,
// and the natural-alignment check. Shared with the fetch-side responder.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output lane_mask_t  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata,
  output logic        misalign
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = rword[{addr_lo, 3'b000} +: 8];
  assign sel_half = rword[{addr_lo[1], 4'b0000} +: 16];

  // funct3[2] marks the unsigned variants, so it gates the sign bit.
  always_comb begin
    be       = '0;
    wdata_sh = wdata;
    rdata    = '0;
    misalign = 1'b0;
    case (funct3)
      F3_LB, F3_LBU: begin
        be       = lane_mask_t'(4'b0001 << addr_lo);
        wdata_sh = {4{wdata[7:0]}};
        rdata    = {{24{sel_byte[7] & ~funct3[2]}}, sel_byte};
      end
      F3_LH, F3_LHU: begin
        misalign = addr_lo[0];
        be       = lane_mask_t'(4'b0011 << {addr_lo[1], 1'b0});
        wdata_sh = {2{wdata[15:0]}};
        rdata    = {{16{sel_half[15] & ~funct3[2]}}, sel_half};
      end
      F3_LW: begin
        misalign = |addr_lo;
        be       = 4'b1111;
        rdata    = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with fixed access latency for the MEM-stage load/store port.
// Optional DMEM_PERF_CNT_EN adds load/store/error/stall performance counters.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus,
  output dmem_state_t       dbg_state
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0]       perf_loads,
  output logic [31:0]       perf_stores,
  output logic [31:0]       perf_errs,
  output logic [31:0]       perf_stall_cycles
`endif
);

  localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept, enter_resp;

  logic        acc_we, acc_err;
  logic [2:0]  acc_f3;
  logic [31:0] acc_addr, acc_wdata;
  logic [IDX_W-1:0] idx;
  logic [31:0] rword, wdata_sh, rdata_ext;
  lane_mask_t  be;
  logic        misalign;

  logic [31:0] mem [DEPTH_WORDS];

  // With LATENCY==1 RESP is entered on the acceptance edge, before the capture
  // registers are loaded, so the access uses the live request fields in IDLE.
  assign acc_we    = (state_q == IDLE) ? bus.req_we     : we_q;
  assign acc_f3    = (state_q == IDLE) ? bus.req_funct3 : f3_q;
  assign acc_addr  = (state_q == IDLE) ? bus.req_addr   : addr_q;
  assign acc_wdata = (state_q == IDLE) ? bus.req_wdata  : wdata_q;
  assign idx       = acc_addr[IDX_W+1:2];
  assign rword     = mem[idx];
  assign acc_err   = misalign | f3_illegal(acc_f3) | (acc_addr[31:2] >= 30'(DEPTH_WORDS));
  assign accept    = (state_q == IDLE) && bus.req_valid;

  dmem_lane_align u_align (
    .funct3   (acc_f3),
    .addr_lo  (acc_addr[1:0]),
    .wdata    (acc_wdata),
    .rword    (rword),
    .be       (be),
    .wdata_sh (wdata_sh),
    .rdata    (rdata_ext),
    .misalign (misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    enter_resp    = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q   <= CNT_INIT;
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end else if (state_q == WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (enter_resp) begin
        err_q   <= acc_err;
        rdata_q <= (acc_err || acc_we) ? 32'd0 : rdata_ext;
      end
    end
  end

  // A reset landing on the RESP-entry edge must not commit the store.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && !acc_err && acc_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign dbg_state     = state_q;

`ifdef DMEM_PERF_CNT_EN
  // Errored requests count only as errors, not as loads or stores.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_loads        <= '0;
      perf_stores       <= '0;
      perf_errs         <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (err_q)     perf_errs   <= perf_errs + 32'd1;
        else if (we_q) perf_stores <= perf_stores + 32'd1;
        else           perf_loads  <= perf_loads + 32'd1;
      end
      if (bus.rsp_valid && !bus.rsp_ready) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
